// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchronizer, mid-bit sampling FSM, optional parity,
// single-entry output register with valid/ready handshake and error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY, STOP_BIT} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         sync_reg;
    logic               rx_s;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [BIT_W-1:0]   bit_n_reg, bit_n_next;
    logic [BITS_N-1:0]  shift_reg, shift_next;
    logic               flag_reg, flag_next;
    logic               bit_end, data_sample, parity_mismatch;
    logic [BITS_N-1:0]  data_rx_reg, data_rx_next;
    logic               valid_reg, valid_next;
    logic               parity_err_reg, parity_err_next;
    logic               frame_err_reg, frame_err_next;
    logic               overrun_reg, overrun_next;
    logic               stop_sample, stop_good, can_load;

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync_reg <= 2'b11;
        else     sync_reg <= {sync_reg[0], uart_in};
    end
    assign rx_s = sync_reg[1];

    assign bit_end = (count_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign parity_mismatch = (PARITY_TYPE == 1) ? (rx_s != ~^shift_reg) :
                             (PARITY_TYPE == 2) ? (rx_s != ^shift_reg)  : 1'b0;

    generate
        for (genvar gi = 0; gi < BITS_N; gi++) begin : g_shift
            assign shift_next[gi] = (data_sample && bit_n_reg == BIT_W'(gi)) ? rx_s : shift_reg[gi];
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            bit_n_reg      <= '0;
            shift_reg      <= '0;
            flag_reg       <= 1'b0;
            data_rx_reg    <= '0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            bit_n_reg      <= bit_n_next;
            shift_reg      <= shift_next;
            flag_reg       <= flag_next;
            data_rx_reg    <= data_rx_next;
            valid_reg      <= valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        bit_n_next  = bit_n_reg;
        flag_next   = flag_reg;
        data_sample = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                bit_n_next = '0;
                if (!rx_s) state_next = START_BIT;
            end
            START_BIT: begin
                if (count_reg == CNT_W'(HALF)) begin
                    count_next = '0;
                    bit_n_next = '0;
                    flag_next  = 1'b0;
                    state_next = rx_s ? IDLE : DATA_BITS;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    count_next  = '0;
                    data_sample = 1'b1;
                    if (bit_n_reg == BIT_W'(BITS_N - 1)) begin
                        bit_n_next = '0;
                        state_next = (PARITY_TYPE != 0) ? PARITY : STOP_BIT;
                    end else begin
                        bit_n_next = bit_n_reg + BIT_W'(1);
                    end
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    count_next = '0;
                    flag_next  = parity_mismatch;
                    state_next = STOP_BIT;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: a good stop bit loads only if the holding register is free this cycle.
    always_comb begin
        stop_sample     = (state_reg == STOP_BIT) && bit_end;
        stop_good       = stop_sample && rx_s;
        can_load        = !valid_reg || ready;
        data_rx_next    = data_rx_reg;
        parity_err_next = parity_err_reg;
        valid_next      = valid_reg && !ready;
        if (stop_good && can_load) begin
            data_rx_next    = shift_reg;
            parity_err_next = flag_reg;
            valid_next      = 1'b1;
        end
        frame_err_next = stop_sample && !rx_s;
        overrun_next   = stop_good && !can_load;
    end

    assign data_rx    = data_rx_reg;
    assign valid      = valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an even-parity and an odd-parity receiver share one serial line;
// expected bytes and error counts come from a frame-level model built from parity arithmetic.
module tb_uart_rx;

    localparam int CPB = 5;

    logic       clk = 1'b0;
    logic       rst, uart_in, ready;
    logic [7:0] data_e, data_o;
    logic       valid_e, perr_e, fe_e, ov_e;
    logic       valid_o, perr_o, fe_o, ov_o;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2)) dut_e (
        .clk(clk), .rst(rst), .uart_in(uart_in), .data_rx(data_e), .valid(valid_e),
        .ready(ready), .parity_err(perr_e), .frame_err(fe_e), .overrun(ov_e));

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(1)) dut_o (
        .clk(clk), .rst(rst), .uart_in(uart_in), .data_rx(data_o), .valid(valid_o),
        .ready(ready), .parity_err(perr_o), .frame_err(fe_o), .overrun(ov_o));

    typedef struct packed {
        logic [7:0] data;
        logic       perr_e;
        logic       valid_o;
        logic [7:0] data_o;
        logic       perr_o;
    } rec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr_e;
        logic       perr_o;
    } exp_t;

    rec_t got_q[$];
    exp_t exp_q[$];
    int   fe_cnt = 0, ov_cnt = 0, fe_o_cnt = 0, ov_o_cnt = 0;
    int   exp_fe = 0, exp_ov = 0;
    int   checks = 0, errors = 0;

    // Record every accepted byte and every error-pulse cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_e && ready)
                got_q.push_back('{data: data_e, perr_e: perr_e, valid_o: valid_o,
                                  data_o: data_o, perr_o: perr_o});
            fe_cnt   += int'(fe_e);
            ov_cnt   += int'(ov_e);
            fe_o_cnt += int'(fe_o);
            ov_o_cnt += int'(ov_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_in = b;
        ticks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stop);
        uart_in = 1'b1;
    endtask

    // Model: a delivered byte's parity error is whether the received parity bit differs
    // from the bit that would make the total count of ones even (or odd).
    function automatic exp_t model_byte(input logic [7:0] d, input logic pbit);
        int ones;
        exp_t e;
        ones     = $countones(d);
        e.data   = d;
        e.perr_e = (int'(pbit) != (ones % 2));
        e.perr_o = (int'(pbit) != (1 - (ones % 2)));
        return e;
    endfunction

    task automatic compare(input string tag);
        int n;
        rec_t g;
        exp_t e;
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[i];
            e = exp_q[i];
            chk({tag, "_data"}, g.data, e.data);
            chk({tag, "_perr_even"}, g.perr_e, e.perr_e);
            chk({tag, "_odd_valid"}, g.valid_o, 1'b1);
            chk({tag, "_odd_data"}, g.data_o, e.data);
            chk({tag, "_perr_odd"}, g.perr_o, e.perr_o);
            $display("byte %s data=0x%02h perr_even=%0d perr_odd=%0d", tag, g.data, g.perr_e, g.perr_o);
        end
        chk({tag, "_frame_err_cnt"}, fe_cnt, exp_fe);
        chk({tag, "_overrun_cnt"}, ov_cnt, exp_ov);
        chk({tag, "_odd_frame_err_cnt"}, fe_o_cnt, exp_fe);
        chk({tag, "_odd_overrun_cnt"}, ov_o_cnt, exp_ov);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic good_frame(input logic [7:0] d, input logic pbit);
        send_frame(d, pbit, 1'b1);
        exp_q.push_back(model_byte(d, pbit));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, data_e, 8'h00);
        chk({tag, "_valid"}, valid_e, 1'b0);
        chk({tag, "_perr"}, perr_e, 1'b0);
        chk({tag, "_frame_err"}, fe_e, 1'b0);
        chk({tag, "_overrun"}, ov_e, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p;

        rst = 1'b1; uart_in = 1'b1; ready = 1'b1;
        ticks(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        ticks(3);

        // 0xA5 with correct even parity, then with the parity bit flipped
        good_frame(8'hA5, 1'b0);
        ticks(4);
        compare("a5_par0");
        good_frame(8'hA5, 1'b1);
        ticks(4);
        compare("a5_par1");

        // Stop bit low: dropped with frame_err, then the same byte framed correctly
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_fe++;
        ticks(4);
        chk("frame_err_valid_low", valid_e, 1'b0);
        compare("3c_bad_stop");
        good_frame(8'h3C, 1'b0);
        ticks(4);
        compare("3c_good");

        // Two-cycle low glitch must not start a frame
        uart_in = 1'b0;
        ticks(2);
        uart_in = 1'b1;
        ticks(20);
        compare("glitch");

        // Randomized frames with random parity correctness and idle gaps
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            good_frame(d, p);
            ticks($urandom_range(0, 3));
        end
        ticks(4);
        compare("random");

        // Back-to-back frames with consumer stalled: second byte overruns
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        exp_ov++;
        ticks(4);
        chk("stall_data_held", data_e, 8'h11);
        chk("stall_valid_held", valid_e, 1'b1);
        chk("stall_perr_held", perr_e, 1'b0);
        ready = 1'b1;
        exp_q.push_back(model_byte(8'h11, 1'b0));
        ticks(1);
        chk("valid_drop_after_accept", valid_e, 1'b0);
        compare("overrun");

        // Reset in the middle of the data bits of 0x55, then a full 0x55 frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        uart_in = 1'b1;
        ticks(3);
        check_reset_outputs("abort_reset");
        rst = 1'b0;
        ticks(2);
        check_reset_outputs("after_abort");
        good_frame(8'h55, 1'b0);
        ticks(4);
        compare("after_reset_55");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
